read_miss_mshr: RTL and testbench



---
 rtl/read_miss_mshr.sv | 236 +++++++++++++++++++++++
 tb/tb_read_miss_mshr.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/read_miss_mshr.sv
// read_miss_mshr: multi-entry read-miss handler with out-of-order fills; define READ_MISS_MSHR_ORDERED_EN to drain in allocation order
module read_miss_mshr #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 512,
    parameter int TID_WIDTH   = 4,
    parameter int ID_WIDTH    = 4,
    parameter int NUM_ENTRIES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             empty_i,
    output logic                             read_en_o,
    input  logic [ADDR_WIDTH+TID_WIDTH-1:0]  ar_i,
    output logic                             arvalid_o,
    input  logic                             arready_i,
    output logic [ADDR_WIDTH-1:0]            araddr_o,
    output logic [ID_WIDTH-1:0]              arid_o,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic [ID_WIDTH-1:0]              rid_i,
    output logic                             write_en_o,
    input  logic                             full_i,
    output logic [DATA_WIDTH+TID_WIDTH-1:0]  wdata_ROB_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wdata_Arbiter_o,
    output logic                             busy_o,
    output logic                             err_o
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [1:0] E_FREE = 2'd0, E_PEND = 2'd1, E_FILLED = 2'd2;
    typedef enum logic {S_IDLE, S_SEND} drain_t;

    logic [1:0]                       st_q [NUM_ENTRIES], st_d [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]            addr_q [NUM_ENTRIES], addr_d [NUM_ENTRIES];
    logic [TID_WIDTH-1:0]             tid_q [NUM_ENTRIES], tid_d [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]            data_q [NUM_ENTRIES], data_d [NUM_ENTRIES];
    logic                             arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]            araddr_q, araddr_d;
    logic [IDX_W-1:0]                 arid_q, arid_d;
    logic                             ready_q, err_q, err_d;
    drain_t                           fsm_q, fsm_d;
    logic [IDX_W-1:0]                 sel_q, sel_d;
    logic                             rob_done_q, rob_done_d, arb_done_q, arb_done_d;
    logic [DATA_WIDTH+TID_WIDTH-1:0]  wrob_q, wrob_d;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] warb_q, warb_d;
    logic                             any_free, fill_found, drain_done;
    logic [IDX_W-1:0]                 free_idx, fill_idx, rid_idx;
`ifdef READ_MISS_MSHR_ORDERED_EN
    logic [IDX_W-1:0]                 ord_q [NUM_ENTRIES], ord_d [NUM_ENTRIES];
    logic [IDX_W-1:0]                 head_q, head_d, tail_q, tail_d;
`else
    logic [IDX_W-1:0]                 last_q, last_d;
`endif

    assign read_en_o       = !rst && !empty_i && any_free && (!arvalid_q || arready_i);
    assign arvalid_o       = arvalid_q;
    assign araddr_o        = araddr_q;
    assign arid_o          = ID_WIDTH'(arid_q);
    assign ready_o         = ready_q;
    assign err_o           = err_q;
    assign wdata_ROB_o     = wrob_q;
    assign wdata_Arbiter_o = warb_q;
    assign rid_idx         = rid_i[IDX_W-1:0];

    // lowest-index free entry for allocation, and overall occupancy
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        busy_o   = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            busy_o = busy_o || (st_q[i] != E_FREE);
            if (st_q[i] == E_FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef READ_MISS_MSHR_ORDERED_EN
    // only the oldest allocation may drain; an empty order queue implies no filled entry
    always_comb begin
        fill_idx   = ord_q[head_q];
        fill_found = st_q[ord_q[head_q]] == E_FILLED;
    end
`else
    // round-robin pick among filled entries, starting after the last drained one
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = '0;
        for (int k = 1; k <= NUM_ENTRIES; k++)
            if (!fill_found && st_q[IDX_W'((int'(last_q) + k) % NUM_ENTRIES)] == E_FILLED) begin
                fill_found = 1'b1;
                fill_idx   = IDX_W'((int'(last_q) + k) % NUM_ENTRIES);
            end
    end
`endif

    // drain FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= S_IDLE;
        else     fsm_q <= fsm_d;
    end

    // drain FSM next state: leave S_SEND once both handshakes have completed
    always_comb begin
        drain_done = fsm_q == S_SEND && (rob_done_q || write_en_o) && (arb_done_q || (valid_o && ready_i));
        fsm_d      = fsm_q;
        if (fsm_q == S_IDLE && fill_found) fsm_d = S_SEND;
        else if (drain_done)               fsm_d = S_IDLE;
    end

    // drain FSM outputs: one ROB push and one Arbiter fill per drained entry
    always_comb begin
        write_en_o = fsm_q == S_SEND && !full_i && !rob_done_q;
        valid_o    = fsm_q == S_SEND && !arb_done_q;
    end

    // entry bookkeeping: allocation, response capture, drain latch and release
    always_comb begin
        st_d       = st_q;
        addr_d     = addr_q;
        tid_d      = tid_q;
        data_d     = data_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arid_d     = arid_q;
        err_d      = err_q;
        sel_d      = sel_q;
        rob_done_d = rob_done_q;
        arb_done_d = arb_done_q;
        wrob_d     = wrob_q;
        warb_d     = warb_q;
`ifdef READ_MISS_MSHR_ORDERED_EN
        ord_d      = ord_q;
        head_d     = head_q;
        tail_d     = tail_q;
`else
        last_d     = last_q;
`endif
        if (read_en_o) begin
            st_d[free_idx]   = E_PEND;
            addr_d[free_idx] = ar_i[ADDR_WIDTH-1:0];
            tid_d[free_idx]  = ar_i[ADDR_WIDTH+TID_WIDTH-1:ADDR_WIDTH];
            arvalid_d        = 1'b1;
            araddr_d         = ar_i[ADDR_WIDTH-1:0];
            arid_d           = free_idx;
`ifdef READ_MISS_MSHR_ORDERED_EN
            ord_d[tail_q]    = free_idx;
            tail_d           = tail_q == IDX_W'(NUM_ENTRIES - 1) ? '0 : tail_q + 1'b1;
`endif
        end else if (arready_i) arvalid_d = 1'b0;
        if (valid_i && ready_q) begin
            if (int'(rid_i) < NUM_ENTRIES && st_q[rid_idx] == E_PEND) begin
                data_d[rid_idx] = data_i;
                st_d[rid_idx]   = E_FILLED;
            end else err_d = 1'b1;
        end
        if (fsm_q == S_IDLE && fill_found) begin
            sel_d      = fill_idx;
            rob_done_d = 1'b0;
            arb_done_d = 1'b0;
            wrob_d     = {tid_q[fill_idx], data_q[fill_idx]};
            warb_d     = {addr_q[fill_idx], data_q[fill_idx]};
`ifndef READ_MISS_MSHR_ORDERED_EN
            last_d     = fill_idx;
`endif
        end
        if (fsm_q == S_SEND) begin
            rob_done_d = rob_done_q || write_en_o;
            arb_done_d = arb_done_q || (valid_o && ready_i);
            if (drain_done) begin
                st_d[sel_q] = E_FREE;
                rob_done_d  = 1'b0;
                arb_done_d  = 1'b0;
`ifdef READ_MISS_MSHR_ORDERED_EN
                head_d      = head_q == IDX_W'(NUM_ENTRIES - 1) ? '0 : head_q + 1'b1;
`endif
            end
        end
    end

    // state registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                st_q[i]   <= E_FREE;
                addr_q[i] <= '0;
                tid_q[i]  <= '0;
                data_q[i] <= '0;
`ifdef READ_MISS_MSHR_ORDERED_EN
                ord_q[i]  <= '0;
`endif
            end
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arid_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= '0;
            rob_done_q <= 1'b0;
            arb_done_q <= 1'b0;
            wrob_q     <= '0;
            warb_q     <= '0;
`ifdef READ_MISS_MSHR_ORDERED_EN
            head_q     <= '0;
            tail_q     <= '0;
`else
            last_q     <= IDX_W'(NUM_ENTRIES - 1);
`endif
        end else begin
            st_q       <= st_d;
            addr_q     <= addr_d;
            tid_q      <= tid_d;
            data_q     <= data_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arid_q     <= arid_d;
            ready_q    <= 1'b1;
            err_q      <= err_d;
            sel_q      <= sel_d;
            rob_done_q <= rob_done_d;
            arb_done_q <= arb_done_d;
            wrob_q     <= wrob_d;
            warb_q     <= warb_d;
`ifdef READ_MISS_MSHR_ORDERED_EN
            ord_q      <= ord_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
`else
            last_q     <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_read_miss_mshr.sv
// tb_read_miss_mshr: directed and randomized stimulus checked every cycle against an entry-level model
module tb_read_miss_mshr;
    localparam int AW = 32, DW = 512, TW = 4, IW = 4, N = 4;

    logic clk = 1'b0, rst, empty_i, arready_i, valid_i, full_i, ready_i;
    logic [AW+TW-1:0] ar_i;
    logic [DW-1:0] data_i;
    logic [IW-1:0] rid_i;
    logic read_en_o, arvalid_o, ready_o, write_en_o, valid_o, busy_o, err_o;
    logic [AW-1:0] araddr_o;
    logic [IW-1:0] arid_o;
    logic [DW+TW-1:0] wdata_ROB_o;
    logic [AW+DW-1:0] wdata_Arbiter_o;

    always #5 clk = ~clk;

    read_miss_mshr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TID_WIDTH(TW), .ID_WIDTH(IW), .NUM_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .empty_i(empty_i), .read_en_o(read_en_o), .ar_i(ar_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arid_o(arid_o),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .rid_i(rid_i),
        .write_en_o(write_en_o), .full_i(full_i), .wdata_ROB_o(wdata_ROB_o),
        .valid_o(valid_o), .ready_i(ready_i), .wdata_Arbiter_o(wdata_Arbiter_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    // model: 0 free, 1 waiting for data, 2 holding data
    int m_st [N];
    logic [AW-1:0] m_addr [N];
    logic [TW-1:0] m_tid [N];
    logic [DW-1:0] m_data [N];
    bit m_arv, m_rdy, m_err, m_on, m_rob, m_arb;
    logic [AW-1:0] m_araddr;
    int m_arid, m_cur, m_last;
    int m_order [$];
    logic [AW-1:0] arb_log [$];
    logic [AW-1:0] exp_ord [4];
    int errors = 0, checks = 0;

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit exp_pop();
        int nf = 0;
        foreach (m_st[i]) if (m_st[i] == 0) nf++;
        return !rst && !empty_i && nf > 0 && (!m_arv || arready_i);
    endfunction

    task automatic model_reset();
        foreach (m_st[i]) begin m_st[i] = 0; m_addr[i] = '0; m_tid[i] = '0; m_data[i] = '0; end
        m_arv = 0; m_rdy = 0; m_err = 0; m_on = 0; m_rob = 0; m_arb = 0;
        m_araddr = '0; m_arid = 0; m_cur = 0; m_last = N - 1;
        m_order.delete();
    endtask

    task automatic model_step();
        bit pop, frob, farb;
        int fi, pick;
        if (rst) begin model_reset(); return; end
        pop = exp_pop();
        frob = m_on && !m_rob && !full_i;
        farb = m_on && !m_arb && ready_i;
        fi = -1;
        for (int i = N - 1; i >= 0; i--) if (m_st[i] == 0) fi = i;
        pick = -1;
        if (!m_on) begin
`ifdef READ_MISS_MSHR_ORDERED_EN
            if (m_order.size() > 0 && m_st[m_order[0]] == 2) pick = m_order[0];
`else
            for (int k = 1; k <= N; k++) if (pick < 0 && m_st[(m_last + k) % N] == 2) pick = (m_last + k) % N;
`endif
        end
        if (valid_i && m_rdy) begin
            if (int'(rid_i) < N && m_st[int'(rid_i)] == 1) begin
                m_data[int'(rid_i)] = data_i;
                m_st[int'(rid_i)] = 2;
            end else m_err = 1;
        end
        if (pop) begin
            m_st[fi] = 1; m_addr[fi] = ar_i[AW-1:0]; m_tid[fi] = ar_i[AW+TW-1:AW];
            m_arv = 1; m_araddr = ar_i[AW-1:0]; m_arid = fi;
            m_order.push_back(fi);
        end else if (arready_i) m_arv = 0;
        if (m_on) begin
            m_rob |= frob;
            m_arb |= farb;
            if (farb) arb_log.push_back(m_addr[m_cur]);
            if (m_rob && m_arb) begin
                m_st[m_cur] = 0; m_on = 0;
                void'(m_order.pop_front());
            end
        end else if (pick >= 0) begin
            m_on = 1; m_cur = pick; m_rob = 0; m_arb = 0; m_last = pick;
        end
        m_rdy = 1;
    endtask

    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare();
        bit busy = 0;
        foreach (m_st[i]) if (m_st[i] != 0) busy = 1;
        chk("read_en", read_en_o, exp_pop());
        chk("arvalid", arvalid_o, m_arv);
        if (m_arv) begin chk("araddr", araddr_o, m_araddr); chk("arid", arid_o, IW'(m_arid)); end
        chk("ready", ready_o, m_rdy);
        chk("write_en", write_en_o, m_on && !m_rob && !full_i);
        chk("valid_o", valid_o, m_on && !m_arb);
        if (m_on) begin
            chk("wdata_rob", wdata_ROB_o, {m_tid[m_cur], m_data[m_cur]});
            chk("wdata_arb", wdata_Arbiter_o, {m_addr[m_cur], m_data[m_cur]});
        end
        if (rst) begin
            chk("rst_rob", wdata_ROB_o, 0); chk("rst_arb", wdata_Arbiter_o, 0);
            chk("rst_araddr", araddr_o, 0); chk("rst_arid", arid_o, 0);
        end
        chk("busy", busy_o, busy);
        chk("err", err_o, m_err);
    endtask

    task automatic step();
        #1 compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic miss(input logic [TW-1:0] t, input logic [AW-1:0] a);
        empty_i = 0; ar_i = {t, a}; step(); empty_i = 1;
    endtask

    task automatic resp(input int id, input logic [DW-1:0] d);
        valid_i = 1; rid_i = IW'(id); data_i = d; step(); valid_i = 0;
    endtask

    task automatic do_reset();
        rst = 1; model_reset(); step(); step(); rst = 0; step(); step();
    endtask

    initial begin
        int pl [$];
`ifdef READ_MISS_MSHR_ORDERED_EN
        exp_ord = '{32'h0, 32'h40, 32'h80, 32'hC0};
`else
        exp_ord = '{32'h80, 32'h0, 32'hC0, 32'h40};
`endif
        empty_i = 1; arready_i = 1; valid_i = 0; full_i = 0; ready_i = 1;
        ar_i = '0; data_i = '0; rid_i = '0;
        do_reset();
        chk("reset_busy", busy_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_ready", ready_o, 1);

        miss(4'd3, 32'h1000);
        chk("t1_arvalid", arvalid_o, 1); chk("t1_araddr", araddr_o, 32'h1000); chk("t1_arid", arid_o, 0);
        step();
        resp(0, {64{8'hAA}});
        step();
        chk("t1_we", write_en_o, 1); chk("t1_valid", valid_o, 1);
        chk("t1_rob", wdata_ROB_o, {4'd3, {64{8'hAA}}});
        chk("t1_arb", wdata_Arbiter_o, {32'h1000, {64{8'hAA}}});
        step(); step();
        chk("t1_free", busy_o, 0);

        arb_log.delete();
        for (int i = 0; i < 4; i++) miss(TW'(i), AW'(i * 'h40));
        empty_i = 0; ar_i = {4'd9, 32'h100};
        #1 chk("t2_full_pop", read_en_o, 0);
        step(); step(); empty_i = 1;
        foreach (exp_ord[i]) begin
            resp(i == 0 ? 2 : i == 1 ? 0 : i == 2 ? 3 : 1, rnd());
            repeat (4) step();
        end
        repeat (4) step();
        chk("t2_count", arb_log.size(), 4);
        foreach (exp_ord[i]) if (i < arb_log.size()) chk("t2_order", arb_log[i], exp_ord[i]);

        miss(4'd5, 32'h2000);
        full_i = 1;
        resp(0, rnd());
        repeat (5) begin step(); chk("t3_stall", write_en_o, 0); end
        full_i = 0;
        repeat (4) step();
        chk("t3_free", busy_o, 0);

        resp(1, rnd());
        chk("t4_err", err_o, 1);
        repeat (3) step();
        chk("t4_err_sticky", err_o, 1);
        chk("t4_quiet", valid_o, 0);
        miss(4'd7, 32'h2400); step(); resp(0, rnd()); repeat (4) step();

        for (int i = 0; i < 3; i++) miss(TW'(i), AW'('h3000 + i * 'h40));
        full_i = 1; ready_i = 0;
        resp(0, rnd());
        step(); step();
        rst = 1; model_reset();
        #1 chk("t5_we", write_en_o, 0); chk("t5_valid", valid_o, 0);
        chk("t5_arvalid", arvalid_o, 0); chk("t5_ready", ready_o, 0);
        step();
        rst = 0; full_i = 0; ready_i = 1;
        step(); step();
        chk("t5_busy", busy_o, 0);
        resp(0, rnd());
        chk("t5_late_err", err_o, 1);
        do_reset();

        arready_i = 0; empty_i = 0; ar_i = {4'd1, 32'h3000};
        step();
        ar_i = {4'd2, 32'h3040};
        repeat (3) begin chk("t6_hold", araddr_o, 32'h3000); chk("t6_nopop", read_en_o, 0); step(); end
        arready_i = 1; step(); empty_i = 1; step();
        chk("t6_next", araddr_o, 32'h3040);

        for (int c = 0; c < 4000; c++) begin
            empty_i = $urandom_range(0, 2) == 0;
            ar_i = {TW'($urandom), AW'($urandom)};
            arready_i = $urandom_range(0, 3) != 0;
            full_i = $urandom_range(0, 3) == 0;
            ready_i = $urandom_range(0, 2) != 0;
            data_i = rnd();
            valid_i = 0;
            pl.delete();
            foreach (m_st[i]) if (m_st[i] == 1) pl.push_back(i);
            if (pl.size() > 0 && $urandom_range(0, 1) == 0) begin
                valid_i = 1; rid_i = IW'(pl[$urandom_range(0, pl.size() - 1)]);
            end
            if (c > 3000 && $urandom_range(0, 99) == 0) begin valid_i = 1; rid_i = IW'($urandom); end
            step();
        end
        empty_i = 1; valid_i = 0; full_i = 0; ready_i = 1;
        repeat (20) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
